// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter/sequencer in front of the shared
// data-memory port. Requester 0 is the instruction fetch unit (read-only),
// requester 1 is the load/store unit (read/write).
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   ifu_req_*  / ifu_resp_*       IFU request / response (valid/ready)
//   lsu_req_*  / lsu_resp_*       LSU request / response (valid/ready)
//   mem_read, mem_write           access strobes to MEM (ACCESS state only)
//   mem_addr, mem_wdata, mem_mask access fields to MEM (zero outside ACCESS)
//   mem_rdata                     combinational read data from MEM
//   busy                          transaction in flight (state != IDLE)
//
// States
//   IDLE   | waiting for a request; grant decided combinationally
//   ACCESS | LATENCY cycles driving MEM; rdata sampled / write strobed last
//   RESP   | response held to the granted unit until it is taken
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_resp_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_req_write,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_mask,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_resp_rdata,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_mask,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_nx;

    // grant encoding: 0 = IFU, 1 = LSU
    logic              grant;
    logic              last_grant;
    logic              grant_nx;
    logic              take;
    logic              last_cycle;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [MASK_W-1:0] lat_mask;
    logic              lat_write;
    logic [DATA_W-1:0] ifu_rdata_q;
    logic [DATA_W-1:0] lsu_rdata_q;

    always_comb begin
        grant_nx = 1'b0;
        if (ifu_req_valid && lsu_req_valid)
            grant_nx = ~last_grant;
        else if (lsu_req_valid)
            grant_nx = 1'b1;
    end

    assign take          = (state == IDLE) && (ifu_req_valid || lsu_req_valid);
    assign ifu_req_ready = take && !grant_nx;
    assign lsu_req_ready = take && grant_nx;
    assign last_cycle    = (state == ACCESS) && (cnt == CNT_LAST);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (take) state_nx = ACCESS;
            ACCESS:  if (last_cycle) state_nx = RESP;
            RESP:    if (grant ? lsu_resp_ready : ifu_resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            cnt         <= '0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_mask    <= '0;
            lat_write   <= 1'b0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (take) begin
                grant      <= grant_nx;
                last_grant <= grant_nx;
                cnt        <= '0;
                lat_addr   <= grant_nx ? lsu_req_addr : ifu_req_addr;
                lat_wdata  <= grant_nx ? lsu_req_wdata : '0;
                lat_mask   <= grant_nx ? lsu_req_mask : '0;
                lat_write  <= grant_nx && lsu_req_write;
            end else if (state == ACCESS) begin
                cnt <= cnt + 1'b1;
            end
            // stores complete with zero data
            if (last_cycle) begin
                if (grant)
                    lsu_rdata_q <= lat_write ? '0 : mem_rdata;
                else
                    ifu_rdata_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_mask  = '0;
        if (state == ACCESS) begin
            mem_read  = !lat_write;
            // one strobe per store, on the final access cycle only
            mem_write = lat_write && last_cycle;
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            mem_mask  = lat_mask;
        end
    end

    assign ifu_resp_valid = (state == RESP) && !grant;
    assign lsu_resp_valid = (state == RESP) && grant;
    assign ifu_resp_rdata = ifu_rdata_q;
    assign lsu_resp_rdata = lsu_rdata_q;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 has LATENCY=1, instance 1 has LATENCY=3.
// A negedge monitor logs grants, pushes expected responses/stores into
// scoreboards on request handshakes and pops them as the DUT produces them.
module tb_mem_arbiter;

    logic        clk;
    logic        rst            [2];
    logic        ifu_req_valid  [2];
    logic        ifu_req_ready  [2];
    logic [31:0] ifu_req_addr   [2];
    logic        ifu_resp_valid [2];
    logic        ifu_resp_ready [2];
    logic [31:0] ifu_resp_rdata [2];
    logic        lsu_req_valid  [2];
    logic        lsu_req_ready  [2];
    logic        lsu_req_write  [2];
    logic [31:0] lsu_req_addr   [2];
    logic [31:0] lsu_req_wdata  [2];
    logic [3:0]  lsu_req_mask   [2];
    logic        lsu_resp_valid [2];
    logic        lsu_resp_ready [2];
    logic [31:0] lsu_resp_rdata [2];
    logic        mem_read       [2];
    logic        mem_write      [2];
    logic [31:0] mem_addr       [2];
    logic [31:0] mem_wdata      [2];
    logic [3:0]  mem_mask       [2];
    logic [31:0] mem_rdata      [2];
    logic        busy           [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int nwrites [2];

    logic [31:0] exp_ifu [2][$];
    logic [31:0] exp_lsu [2][$];
    logic [67:0] exp_st  [2][$];
    int          gw_who  [2][$];
    int          gw_cyc  [2][$];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst[0]),
        .ifu_req_valid(ifu_req_valid[0]), .ifu_req_ready(ifu_req_ready[0]),
        .ifu_req_addr(ifu_req_addr[0]), .ifu_resp_valid(ifu_resp_valid[0]),
        .ifu_resp_ready(ifu_resp_ready[0]), .ifu_resp_rdata(ifu_resp_rdata[0]),
        .lsu_req_valid(lsu_req_valid[0]), .lsu_req_ready(lsu_req_ready[0]),
        .lsu_req_write(lsu_req_write[0]), .lsu_req_addr(lsu_req_addr[0]),
        .lsu_req_wdata(lsu_req_wdata[0]), .lsu_req_mask(lsu_req_mask[0]),
        .lsu_resp_valid(lsu_resp_valid[0]), .lsu_resp_ready(lsu_resp_ready[0]),
        .lsu_resp_rdata(lsu_resp_rdata[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_mask(mem_mask[0]), .mem_rdata(mem_rdata[0]),
        .busy(busy[0])
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst(rst[1]),
        .ifu_req_valid(ifu_req_valid[1]), .ifu_req_ready(ifu_req_ready[1]),
        .ifu_req_addr(ifu_req_addr[1]), .ifu_resp_valid(ifu_resp_valid[1]),
        .ifu_resp_ready(ifu_resp_ready[1]), .ifu_resp_rdata(ifu_resp_rdata[1]),
        .lsu_req_valid(lsu_req_valid[1]), .lsu_req_ready(lsu_req_ready[1]),
        .lsu_req_write(lsu_req_write[1]), .lsu_req_addr(lsu_req_addr[1]),
        .lsu_req_wdata(lsu_req_wdata[1]), .lsu_req_mask(lsu_req_mask[1]),
        .lsu_resp_valid(lsu_resp_valid[1]), .lsu_resp_ready(lsu_resp_ready[1]),
        .lsu_resp_rdata(lsu_resp_rdata[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_mask(mem_mask[1]), .mem_rdata(mem_rdata[1]),
        .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // memory model: fixed pattern with one well-known word
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h8000_0010) ? 32'hDEAD_BEEF : ((a ^ 32'h5A5A_0000) + 32'h11);
    endfunction

    always_comb begin
        for (int d = 0; d < 2; d++) mem_rdata[d] = mem_model(mem_addr[d]);
    end

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                exp_ifu[d].delete();
                exp_lsu[d].delete();
                exp_st[d].delete();
            end else begin
                check_eq("rw_excl", 72'(mem_read[d] & mem_write[d]), 72'(0));
                if (ifu_req_valid[d] && ifu_req_ready[d]) begin
                    gw_who[d].push_back(0);
                    gw_cyc[d].push_back(cyc);
                    exp_ifu[d].push_back(mem_model(ifu_req_addr[d]));
                end
                if (lsu_req_valid[d] && lsu_req_ready[d]) begin
                    gw_who[d].push_back(1);
                    gw_cyc[d].push_back(cyc);
                    exp_lsu[d].push_back(lsu_req_write[d] ? 32'h0 : mem_model(lsu_req_addr[d]));
                    if (lsu_req_write[d])
                        exp_st[d].push_back({lsu_req_addr[d], lsu_req_wdata[d], lsu_req_mask[d]});
                end
                if (ifu_resp_valid[d] && ifu_resp_ready[d]) begin
                    check_eq("ifu_resp_q", 72'(exp_ifu[d].size() != 0), 72'(1));
                    if (exp_ifu[d].size() != 0)
                        check_eq("ifu_rdata", 72'(ifu_resp_rdata[d]), 72'(exp_ifu[d].pop_front()));
                end
                if (lsu_resp_valid[d] && lsu_resp_ready[d]) begin
                    check_eq("lsu_resp_q", 72'(exp_lsu[d].size() != 0), 72'(1));
                    if (exp_lsu[d].size() != 0)
                        check_eq("lsu_rdata", 72'(lsu_resp_rdata[d]), 72'(exp_lsu[d].pop_front()));
                end
                if (mem_write[d]) begin
                    nwrites[d]++;
                    check_eq("st_q", 72'(exp_st[d].size() != 0), 72'(1));
                    if (exp_st[d].size() != 0)
                        check_eq("st_fields", 72'({mem_addr[d], mem_wdata[d], mem_mask[d]}),
                                 72'(exp_st[d].pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int d);
        rst[d] = 1'b1;
        tick();
        tick();
        rst[d] = 1'b0;
    endtask

    task automatic req(input int d, input bit lsu, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] m);
        bit done = 1'b0;
        if (lsu) begin
            lsu_req_valid[d] = 1'b1; lsu_req_write[d] = wr; lsu_req_addr[d] = a;
            lsu_req_wdata[d] = wd;   lsu_req_mask[d]  = m;
        end else begin
            ifu_req_valid[d] = 1'b1; ifu_req_addr[d] = a;
        end
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = lsu ? lsu_req_ready[d] : ifu_req_ready[d];
            tick();
        end
        if (lsu) lsu_req_valid[d] = 1'b0;
        else     ifu_req_valid[d] = 1'b0;
        check_eq("req_handshake", 72'(done), 72'(1));
    endtask

    task automatic check_grants(input string tag, input int d, input int n,
                                input bit alternate, input int spacing);
        check_eq({tag, "_count"}, 72'(gw_who[d].size()), 72'(n));
        for (int i = 0; i < gw_who[d].size() && i < n; i++) begin
            check_eq({tag, "_who"}, 72'(gw_who[d][i]), 72'(alternate ? (i % 2) : 0));
            if (i > 0)
                check_eq({tag, "_gap"}, 72'(gw_cyc[d][i] - gw_cyc[d][i-1]), 72'(spacing));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int nw0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; nwrites[d] = 0;
            ifu_req_valid[d] = 1'b0; ifu_req_addr[d] = '0; ifu_resp_ready[d] = 1'b1;
            lsu_req_valid[d] = 1'b0; lsu_req_write[d] = 1'b0; lsu_req_addr[d] = '0;
            lsu_req_wdata[d] = '0; lsu_req_mask[d] = '0; lsu_resp_ready[d] = 1'b1;
        end
        #2;
        do_reset(0);
        do_reset(1);

        // reset state
        @(negedge clk);
        check_eq("rst_busy", 72'(busy[0]), 72'(0));
        check_eq("rst_mem", 72'({mem_read[0], mem_write[0], mem_addr[0], mem_wdata[0], mem_mask[0]}), 72'(0));
        check_eq("rst_resp", 72'({ifu_resp_valid[0], lsu_resp_valid[0], ifu_req_ready[0], lsu_req_ready[0]}), 72'(0));
        check_eq("rst_rdata", 72'({ifu_resp_rdata[0], lsu_resp_rdata[0]}), 72'(0));
        tick();

        // single IFU read, LATENCY=1
        ifu_req_valid[0] = 1'b1; ifu_req_addr[0] = 32'h8000_0010;
        @(negedge clk);
        check_eq("t1_ready", 72'(ifu_req_ready[0]), 72'(1));
        check_eq("t1_busy_t0", 72'(busy[0]), 72'(0));
        tick();
        ifu_req_valid[0] = 1'b0;
        @(negedge clk);
        check_eq("t1_mem_read", 72'(mem_read[0]), 72'(1));
        check_eq("t1_mem_write", 72'(mem_write[0]), 72'(0));
        check_eq("t1_mem_addr", 72'(mem_addr[0]), 72'(32'h8000_0010));
        check_eq("t1_busy_t1", 72'(busy[0]), 72'(1));
        tick();
        @(negedge clk);
        check_eq("t1_resp_valid", 72'(ifu_resp_valid[0]), 72'(1));
        check_eq("t1_rdata", 72'(ifu_resp_rdata[0]), 72'(32'hDEAD_BEEF));
        check_eq("t1_busy_t2", 72'(busy[0]), 72'(1));
        check_eq("t1_mem_idle", 72'({mem_read[0], mem_addr[0]}), 72'(0));
        tick();
        @(negedge clk);
        check_eq("t1_busy_t3", 72'(busy[0]), 72'(0));
        tick();

        // round robin under ties, LATENCY=1
        do_reset(0);
        gw_who[0].delete(); gw_cyc[0].delete();
        for (int k = 0; k < 2; k++) begin
            fork
                req(0, 1'b0, 1'b0, 32'h0000_0100 + 32'(k * 4), 32'h0, 4'h0);
                req(0, 1'b1, 1'b0, 32'h0000_0200 + 32'(k * 4), 32'h0, 4'h0);
            join
        end
        repeat (4) tick();
        check_grants("t2", 0, 4, 1'b1, 3);

        // IFU alone, valid held, LATENCY=1
        do_reset(0);
        gw_who[0].delete(); gw_cyc[0].delete();
        ifu_req_valid[0] = 1'b1; ifu_req_addr[0] = 32'h8000_0020;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_eq("t6_lsu_ready", 72'(lsu_req_ready[0]), 72'(0));
            tick();
        end
        ifu_req_valid[0] = 1'b0;
        repeat (4) tick();
        check_grants("t6", 0, 4, 1'b0, 3);

        // LSU load with response backpressure, IFU waiting
        do_reset(0);
        lsu_resp_ready[0] = 1'b0;
        req(0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
        ifu_req_valid[0] = 1'b1; ifu_req_addr[0] = 32'h0000_0400;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t4_resp_held", 72'(lsu_resp_valid[0]), 72'(1));
            check_eq("t4_rdata_stable", 72'(lsu_resp_rdata[0]), 72'(mem_model(32'h0000_0300)));
            check_eq("t4_ifu_blocked", 72'(ifu_req_ready[0]), 72'(0));
            tick();
        end
        lsu_resp_ready[0] = 1'b1;
        @(negedge clk);
        check_eq("t4_resp_hs", 72'(lsu_resp_valid[0]), 72'(1));
        check_eq("t4_ifu_hs_cycle", 72'(ifu_req_ready[0]), 72'(0));
        tick();
        @(negedge clk);
        check_eq("t4_ifu_after", 72'(ifu_req_ready[0]), 72'(1));
        tick();
        ifu_req_valid[0] = 1'b0;
        repeat (3) tick();

        // LSU store, LATENCY=3
        do_reset(1);
        lsu_req_valid[1] = 1'b1; lsu_req_write[1] = 1'b1; lsu_req_addr[1] = 32'h8000_0004;
        lsu_req_wdata[1] = 32'h1234_5678; lsu_req_mask[1] = 4'b0011;
        @(negedge clk);
        check_eq("t3_ready", 72'(lsu_req_ready[1]), 72'(1));
        nw0 = nwrites[1];
        tick();
        lsu_req_valid[1] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check_eq("t3_mem_read", 72'(mem_read[1]), 72'(0));
            check_eq("t3_mem_write", 72'(mem_write[1]), 72'(k == 3));
            if (k == 3)
                check_eq("t3_fields", 72'({mem_addr[1], mem_wdata[1], mem_mask[1]}),
                         72'({32'h8000_0004, 32'h1234_5678, 4'b0011}));
            check_eq("t3_resp_valid", 72'(lsu_resp_valid[1]), 72'(k == 4));
            if (k == 4)
                check_eq("t3_rdata", 72'(lsu_resp_rdata[1]), 72'(0));
            tick();
        end
        check_eq("t3_one_write", 72'(nwrites[1] - nw0), 72'(1));
        repeat (2) tick();

        // reset during ACCESS of a store, LATENCY=3
        do_reset(1);
        lsu_req_valid[1] = 1'b1; lsu_req_write[1] = 1'b1; lsu_req_addr[1] = 32'h8000_0008;
        lsu_req_wdata[1] = 32'hCAFE_F00D; lsu_req_mask[1] = 4'b1111;
        @(negedge clk);
        check_eq("t5_ready", 72'(lsu_req_ready[1]), 72'(1));
        nw0 = nwrites[1];
        tick();
        lsu_req_valid[1] = 1'b0;
        tick();
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        @(negedge clk);
        check_eq("t5_busy", 72'(busy[1]), 72'(0));
        check_eq("t5_mem", 72'({mem_read[1], mem_write[1], mem_addr[1], mem_wdata[1], mem_mask[1]}), 72'(0));
        check_eq("t5_resp", 72'({ifu_resp_valid[1], lsu_resp_valid[1], ifu_req_ready[1], lsu_req_ready[1]}), 72'(0));
        tick();
        gw_who[1].delete(); gw_cyc[1].delete();
        fork
            req(1, 1'b0, 1'b0, 32'h0000_0500, 32'h0, 4'h0);
            req(1, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'h0);
        join
        repeat (6) tick();
        check_eq("t5_no_write", 72'(nwrites[1] - nw0), 72'(0));
        check_grants("t5", 1, 2, 1'b1, 5);

        for (int d = 0; d < 2; d++) begin
            check_eq("end_ifu_q", 72'(exp_ifu[d].size()), 72'(0));
            check_eq("end_lsu_q", 72'(exp_lsu[d].size()), 72'(0));
            check_eq("end_st_q", 72'(exp_st[d].size()), 72'(0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the shared data-memory port.
- Requester 0 is the instruction fetch unit (IFU, read-only). Requester 1 is the load/store unit (LSU, read/write).
- Sits between both units and the MEM block. It drives the mem_read/mem_write/mem_addr/mem_wdata/mem_mask interface and captures combinational mem_rdata.
- Serializes accesses, guarantees single-cycle write strobes (so external writes fire exactly once), and returns responses over valid/ready.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; mask width is DATA_W/8.
- LATENCY, 1, ACCESS-state cycles per transaction (>=1); rdata is sampled in the last one.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_req_addr  in  ADDR_W  IFU address.
- ifu_resp_valid  out  1  IFU read data valid.
- ifu_resp_ready  in  1  IFU takes response.
- ifu_resp_rdata  out  DATA_W  IFU read data.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted.
- lsu_req_write  in  1  1=store, 0=load.
- lsu_req_addr  in  ADDR_W  LSU address.
- lsu_req_wdata  in  DATA_W  store data.
- lsu_req_mask  in  DATA_W/8  byte enables.
- lsu_resp_valid  out  1  LSU load data or store completion.
- lsu_resp_ready  in  1  LSU takes response.
- lsu_resp_rdata  out  DATA_W  load data; 0 for stores.
- mem_read  out  1  to MEM.
- mem_write  out  1  to MEM.
- mem_addr  out  ADDR_W  to MEM.
- mem_wdata  out  DATA_W  to MEM.
- mem_mask  out  DATA_W/8  to MEM.
- mem_rdata  in  DATA_W  combinational read data from MEM.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, last_grant=LSU (so the first tie goes to IFU).
  - Latched req regs, resp_rdata regs and access counter all cleared.
  - All outputs 0: req_ready, resp_valid, mem_*, busy.
  - Reset mid-transaction aborts it: no mem_write is issued after reset and any pending response is dropped.
- FSM has three states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - Grant is combinational. Only one valid: grant it. Both valid: grant the requester != last_grant (round-robin).
  - The granted unit's req_ready=1 in this cycle only when its valid=1; the other req_ready=0.
  - On handshake, latch addr/wdata/mask/write (IFU write=0), record grant, set last_grant, counter=0, go to ACCESS.
  - No valid: stay in IDLE with all mem_* =0.
- ACCESS (LATENCY cycles):
  - mem_addr/mem_wdata/mem_mask driven from the latched regs.
  - Read: mem_read=1 every ACCESS cycle. On the last cycle (counter==LATENCY-1), capture mem_rdata into the granted unit's resp_rdata.
  - Write: mem_write=1 only on the last ACCESS cycle (exactly one cycle per store); resp_rdata=0.
  - Counter increments each cycle; after the last cycle go to RESP.
- RESP:
  - The granted unit's resp_valid=1 and resp_rdata stays stable.
  - mem_read=mem_write=0; mem_addr/wdata/mask=0.
  - Stays in RESP while resp_ready=0 (backpressure, unbounded).
  - On resp_valid&&resp_ready, go to IDLE the next cycle. No new grant in a RESP cycle.
- Latency: handshake cycle T -> ACCESS T+1..T+LATENCY -> resp_valid at T+LATENCY+1. Minimum back-to-back spacing is LATENCY+2 cycles.
- Outside ACCESS, mem_read and mem_write are never 1. They are never both 1.
- Requests that are not granted must not be consumed. Requesters hold valid/fields stable until ready.
- Stores to any address (including outside local DMEM) go through unchanged. No address checking.

Test Plan:
- Reset then single IFU read addr 0x80000010, MEM returns 0xDEADBEEF, LATENCY=1: req_ready at T0, mem_read=1 at T1 with mem_addr=0x80000010, ifu_resp_valid=1 with rdata 0xDEADBEEF at T2, busy=1 T1..T2.
- Both valid in the same cycle, repeated 4 times with resp_ready=1: grants are IFU, LSU, IFU, LSU; no request lost; each access spaced 3 cycles.
- LSU store addr 0x80000004, wdata 0x12345678, mask 4'b0011, LATENCY=3: mem_write=1 for exactly one cycle (T3) with those values, mem_read=0 throughout, lsu_resp_valid at T4 with rdata 0.
- Backpressure: LSU load with lsu_resp_ready=0 for 5 cycles: resp_valid held with stable rdata; a pending ifu_req_valid gets no ready until the cycle after the LSU response handshake.
- Reset asserted during ACCESS of a store (LATENCY=3, reset at T2): no mem_write pulse ever, all outputs 0 next cycle, state IDLE, next tie granted to IFU.
- Only ifu_req_valid asserted and held continuously: IFU granted every 3 cycles (LATENCY=1); lsu_req_ready stays 0.
